// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter/sequencer for the RegFile write port; optional init sweep under REGFILE_ARB_INIT_EN.
// Latency: handshake in cycle t drives WE/ADDR_IN/D_IN in cycle t+1; one write per cycle.
// Backpressure: REQ_READY is a one-hot grant, held low during reset and while the sweep owns the port.
module regfile_wr_arbiter #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int lo         = 0,
    parameter int hi         = 31,
    parameter logic [data_width-1:0] init_value = '0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [3:0]                REQ_VALID,
    input  logic [4*addr_width-1:0]   REQ_ADDR,
    input  logic [4*data_width-1:0]   REQ_DATA,
    output logic [3:0]                REQ_READY,
    input  logic                      INIT_START,
    output logic                      INIT_BUSY,
    output logic                      INIT_DONE,
    output logic                      ERR_OOR,
    output logic                      WE,
    output logic [addr_width-1:0]     ADDR_IN,
    output logic [data_width-1:0]     D_IN
);

    logic [1:0]            ptr;
    logic [1:0]            gnt_idx;
    logic                  gnt_any;
    logic [3:0]            gnt;
    logic                  arb_en;
    logic                  xfer;
    logic                  in_range;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_data;

`ifdef REGFILE_ARB_INIT_EN
    localparam logic [0:0] S_ARB  = 1'b0;
    localparam logic [0:0] S_INIT = 1'b1;
    localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

    logic [0:0]            state;
    logic [addr_width-1:0] cnt;

    assign arb_en    = !RST && (state == S_ARB);
    assign INIT_BUSY = (state == S_INIT);
`else
    wire unused_init_start = INIT_START;

    assign arb_en    = !RST;
    assign INIT_BUSY = 1'b0;
    assign INIT_DONE = 1'b0;
`endif

    // First valid requester at or after ptr, wrapping mod 4.
    always_comb begin
        logic [1:0] idx;
        idx     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        gnt     = '0;
        for (int j = 0; j < 4; j++) begin
            idx = ptr + 2'(j);
            if (!gnt_any && REQ_VALID[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    assign REQ_READY = arb_en ? gnt : 4'b0000;
    assign xfer      = arb_en && gnt_any;
    assign sel_addr  = REQ_ADDR[int'(gnt_idx)*addr_width +: addr_width];
    assign sel_data  = REQ_DATA[int'(gnt_idx)*data_width +: data_width];
    // Compare in int so a zero lo does not collapse into a constant-true unsigned compare.
    assign in_range  = (int'(sel_addr) >= lo) && (int'(sel_addr) <= hi);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr     <= '0;
            WE      <= 1'b0;
            ADDR_IN <= '0;
            D_IN    <= '0;
            ERR_OOR <= 1'b0;
`ifdef REGFILE_ARB_INIT_EN
            state     <= S_ARB;
            cnt       <= LO_A;
            INIT_DONE <= 1'b0;
`endif
        end else begin
`ifdef REGFILE_ARB_INIT_EN
            INIT_DONE <= 1'b0;
            if (state == S_INIT) begin
                WE      <= 1'b1;
                ADDR_IN <= cnt;
                D_IN    <= init_value;
                cnt     <= cnt + 1'b1;
                // Terminates on the exact compare, so hi at the top of the range never relies on wrap.
                if (cnt == HI_A) begin
                    INIT_DONE <= 1'b1;
                    state     <= S_ARB;
                end
            end else begin
                if (INIT_START) begin
                    state <= S_INIT;
                    cnt   <= LO_A;
                end
`else
            begin
`endif
                WE <= xfer && in_range;
                if (xfer) begin
                    ptr <= gnt_idx + 2'd1;
                    if (in_range) begin
                        ADDR_IN <= sel_addr;
                        D_IN    <= sel_data;
                    end else begin
                        ERR_OOR <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench: two arbiter instances (full range and a narrow lo..hi window) checked every cycle against a behavioural model.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  vld  [2];
    logic [19:0] radr [2];
    logic [127:0] rdat [2];
    logic [3:0]  rdy  [2];
    logic        busy [2];
    logic        done [2];
    logic        err  [2];
    logic        we   [2];
    logic [4:0]  addr [2];
    logic [31:0] din  [2];

    logic [31:0] rf [2][32];

    int checks = 0;
    int errors = 0;

    int          LO [2] = '{0, 3};
    int          HI [2] = '{31, 15};
    logic [31:0] IV [2] = '{32'hC0DE_0001, 32'h0000_BEEF};

    int          m_ptr  [2];
    bit          m_init [2];
    int          m_cnt  [2];
    logic        m_we   [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic        m_done [2];
    logic        m_err  [2];
    logic [3:0]  m_gnt  [2];

    regfile_wr_arbiter #(.addr_width(5), .data_width(32), .lo(0), .hi(31), .init_value(32'hC0DE_0001)) dut_a (
        .CLK(clk), .RST(rst), .REQ_VALID(vld[0]), .REQ_ADDR(radr[0]), .REQ_DATA(rdat[0]),
        .REQ_READY(rdy[0]), .INIT_START(start), .INIT_BUSY(busy[0]), .INIT_DONE(done[0]),
        .ERR_OOR(err[0]), .WE(we[0]), .ADDR_IN(addr[0]), .D_IN(din[0]));

    regfile_wr_arbiter #(.addr_width(5), .data_width(32), .lo(3), .hi(15), .init_value(32'h0000_BEEF)) dut_b (
        .CLK(clk), .RST(rst), .REQ_VALID(vld[1]), .REQ_ADDR(radr[1]), .REQ_DATA(rdat[1]),
        .REQ_READY(rdy[1]), .INIT_START(start), .INIT_BUSY(busy[1]), .INIT_DONE(done[1]),
        .ERR_OOR(err[1]), .WE(we[1]), .ADDR_IN(addr[1]), .D_IN(din[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the RegFile behind each arbiter.
    always @(posedge clk) if (we[0]) rf[0][addr[0]] <= din[0];
    always @(posedge clk) if (we[1]) rf[1][addr[1]] <= din[1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_ptr[k] = 0; m_init[k] = 0; m_cnt[k] = LO[k];
        m_we[k] = 0; m_addr[k] = '0; m_data[k] = '0; m_done[k] = 0; m_err[k] = 0;
        m_gnt[k] = '0;
    endtask

    // Check the current cycle at negedge, advance the model, then move past the next posedge.
    task automatic step();
        int         g;
        int         r;
        int         a;
        logic [3:0] er;
        string      p;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            p  = (k == 0) ? "a." : "b.";
            g  = -1;
            er = '0;
            if (!rst && !m_init[k])
                for (int j = 0; j < 4; j++) begin
                    r = (m_ptr[k] + j) % 4;
                    if (g < 0 && vld[k][r]) g = r;
                end
            if (g >= 0) er[g] = 1'b1;
            chk({p, "ready"}, 64'(rdy[k]), 64'(er));
            chk({p, "we"},    64'(we[k]),  64'(m_we[k]));
            chk({p, "addr"},  64'(addr[k]), 64'(m_addr[k]));
            chk({p, "din"},   64'(din[k]), 64'(m_data[k]));
            chk({p, "err"},   64'(err[k]), 64'(m_err[k]));
            chk({p, "busy"},  64'(busy[k]), 64'(m_init[k]));
            chk({p, "done"},  64'(done[k]), 64'(m_done[k]));
            m_gnt[k] = er;
            if (rst) begin
                model_reset(k);
            end else if (m_init[k]) begin
                m_we[k]   = 1'b1;
                m_addr[k] = 5'(m_cnt[k]);
                m_data[k] = IV[k];
                m_done[k] = (m_cnt[k] == HI[k]);
                if (m_done[k]) m_init[k] = 0;
                m_cnt[k]++;
            end else begin
                m_done[k] = 1'b0;
                m_we[k]   = 1'b0;
                if (g >= 0) begin
                    a = int'(radr[k][g*5 +: 5]);
                    if (a >= LO[k] && a <= HI[k]) begin
                        m_we[k]   = 1'b1;
                        m_addr[k] = 5'(a);
                        m_data[k] = rdat[k][g*32 +: 32];
                    end else begin
                        m_err[k] = 1'b1;
                    end
                    m_ptr[k] = (g + 1) % 4;
                end
`ifdef REGFILE_ARB_INIT_EN
                if (start) begin
                    m_init[k] = 1;
                    m_cnt[k]  = LO[k];
                end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_both(input logic [3:0] v, input logic [19:0] ad, input logic [127:0] dt);
        for (int k = 0; k < 2; k++) begin
            vld[k] = v; radr[k] = ad; rdat[k] = dt;
        end
    endtask

    // Requesters still waiting keep their request; others draw a new one.
    task automatic refresh(input int pct);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++)
                if (!vld[k][i] || m_gnt[k][i]) begin
                    vld[k][i]          = ($urandom_range(99) < pct);
                    radr[k][i*5 +: 5]  = 5'($urandom);
                    rdat[k][i*32 +: 32] = $urandom;
                end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        set_both(4'h0, '0, '0);
        model_reset(0); model_reset(1);
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // All four requesters held valid: grant order 0,1,2,3,0.
        set_both(4'hF, {5'd4, 5'd3, 5'd2, 5'd1},
                 {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        repeat (6) step();
        set_both(4'h0, '0, '0);
        step();

        // Requester 2 alone right after reset, then everyone: next order starts at 3.
        rst = 1'b1; step(); rst = 1'b0;
        set_both(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {32'h0, 32'h0000_1234, 32'h0, 32'h0});
        step();
        set_both(4'hF, {5'd9, 5'd8, 5'd7, 5'd6}, {32'h44, 32'h33, 32'h22, 32'h11});
        repeat (4) step();

        // Address 20 is out of range for the narrow instance; the flag must stick until reset.
        rst = 1'b1; step(); rst = 1'b0;
        set_both(4'b0001, {15'd0, 5'd20}, {96'd0, 32'h5555_AAAA});
        step();
        set_both(4'h0, '0, '0);
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        step();

        // Sweep started alongside a requester-1 grant.
        set_both(4'b0010, {10'd0, 5'd7, 5'd0}, {64'd0, 32'h7777_0007, 32'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        set_both(4'h0, '0, '0);
        repeat (36) step();
`ifdef REGFILE_ARB_INIT_EN
        for (int i = 0; i < 32; i++) chk("a.rf", 64'(rf[0][i]), 64'(IV[0]));
        for (int i = 3; i <= 15; i++) chk("b.rf", 64'(rf[1][i]), 64'(IV[1]));
`endif

        // Reset in cycle 10 of a sweep after ptr has moved; the next all-valid grant must be 0.
        set_both(4'b0010, '0, '0);
        start = 1'b1;
        step();
        start = 1'b0;
        set_both(4'h0, '0, '0);
        repeat (9) step();
        rst = 1'b1; step(); rst = 1'b0;
        step();
        set_both(4'hF, {5'd12, 5'd11, 5'd10, 5'd9}, {32'h4, 32'h3, 32'h2, 32'h1});
        repeat (3) step();

        // Random traffic with occasional sweeps and resets.
        set_both(4'h0, '0, '0);
        for (int c = 0; c < 600; c++) begin
            refresh(60);
            start = ($urandom_range(49) == 0);
            rst   = ($urandom_range(149) == 0);
            step();
        end
        start = 1'b0; rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
